// File: rtl/div_24bit_seq_if.sv
// Start/done handshake and operand/result bundle for the 48/24 sequential divider.
interface div_24bit_seq_if;
    logic        start;
    logic [47:0] dividend;
    logic [23:0] divisor;
    logic        busy;
    logic        done;
    logic [23:0] quotient;
    logic [23:0] remainder;
    logic        ovf;
    logic        dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dz
    );
endinterface

// File: rtl/div_24bit_seq.sv
// Radix-2 restoring divider: 48-bit dividend / 24-bit divisor, one quotient bit per clock.
// Overflow and divide-by-zero short-circuit through a one-cycle pending stage.
module div_24bit_seq (
    input  logic             clk,
    input  logic             rst_n,
    div_24bit_seq_if.slave   bus
);
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [23:0] r, q, d;
    logic [24:0] t;
    logic        ge, last, accept, ovf_in;
    logic [23:0] r_nxt, q_nxt;
    logic        pend, pend_dz;

    assign accept = (state == IDLE) && bus.start;
    assign ovf_in = (bus.divisor == 24'd0) || (bus.dividend[47:24] >= bus.divisor);

    // r < d holds in CALC, so {r,q[23]} < 2d and bit 24 of t is exactly the borrow.
    assign t     = {r, q[23]} - {1'b0, d};
    assign ge    = ~t[24];
    assign r_nxt = ge ? t[23:0] : {r[22:0], q[23]};
    assign q_nxt = {q[22:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !ovf_in) state_nxt = CALC;
            CALC:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC);
        last     = (state == CALC) && (cnt == 5'd23);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            r             <= '0;
            q             <= '0;
            d             <= '0;
            pend          <= 1'b0;
            pend_dz       <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.dz        <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            pend     <= 1'b0;
            if (state == CALC) begin
                r   <= r_nxt;
                q   <= q_nxt;
                cnt <= cnt + 5'd1;
                if (last) begin
                    bus.quotient  <= q_nxt;
                    bus.remainder <= r_nxt;
                    bus.done      <= 1'b1;
                end
            end
            if (accept) begin
                if (ovf_in) begin
                    pend    <= 1'b1;
                    pend_dz <= (bus.divisor == 24'd0);
                end else begin
                    r       <= bus.dividend[47:24];
                    q       <= bus.dividend[23:0];
                    d       <= bus.divisor;
                    cnt     <= '0;
                    bus.ovf <= 1'b0;
                    bus.dz  <= 1'b0;
                end
            end
            // A pending overflow result must stay visible alongside its own done pulse.
            if (pend) begin
                bus.quotient  <= 24'hFFFFFF;
                bus.remainder <= '0;
                bus.ovf       <= 1'b1;
                bus.dz        <= pend_dz;
                bus.done      <= 1'b1;
            end
        end
    end
endmodule
